vpipe_issue_stage: RTL and testbench

Upstream issue stage for the vpipe verification pipeline. Accepts 4-bit operands from the instruction source with a valid/ready handshake, buffers them in a small FIFO, and presents them to the decode stage (stage1). It also tags exactly one "tracked" instruction per reset epoch. It holds that instruction's operand and expected result (operand*2+1) as stable auxiliary state, so the downstream pipeline properties can be written against it.

---
 rtl/vpipe_pkg.sv | 19 +
 rtl/vpipe_fifo.sv | 58 +++++
 rtl/vpipe_issue_stage.sv | 100 ++++++++++
 tb/tb_vpipe_issue_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/vpipe_pkg.sv
// rtl/vpipe_pkg.sv - shared vpipe types, widths and the expected-result function
// Entry layout and comp() are shared with the downstream stage model.
package vpipe_pkg;

   localparam int DW_DEFAULT = 4;
   localparam int SEQ_W      = 4;

   typedef struct packed {
      logic [DW_DEFAULT-1:0] data;
      logic                  track;
      logic [SEQ_W-1:0]      seq;
   } entry_t;

   // x*2+1 with the carry out of the top bit discarded
   function automatic logic [DW_DEFAULT-1:0] comp(input logic [DW_DEFAULT-1:0] x);
      return {x[DW_DEFAULT-2:0], 1'b1};
   endfunction

endpackage

// File: rtl/vpipe_fifo.sv
// rtl/vpipe_fifo.sv - circular buffer with occupancy count for the issue stage
// Callers qualify push_i/pop_i with full_o/empty_o; this block trusts them.
module vpipe_fifo
   import vpipe_pkg::*;
#(
   parameter int W     = 9,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [W-1:0]               push_data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               head_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push_i) - CW'(pop_i);
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is read while count is zero.
   always_ff @(posedge clk) begin
      if (!rst && push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/vpipe_issue_stage.sv
// rtl/vpipe_issue_stage.sv - operand issue stage with FIFO, sequence tags and tracked-instruction capture
// Exactly one pushed operand per reset epoch is tagged as tracked and its operand/result held stable.
module vpipe_issue_stage
   import vpipe_pkg::*;
#(
   parameter int DW    = DW_DEFAULT,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [DW-1:0]          in_data,
   input  logic                   in_track,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [DW-1:0]          out_data,
   output logic                   out_track,
   output logic [SEQ_W-1:0]       out_seq,
   input  logic                   out_ready,
   output logic [DW-1:0]          track_val,
   output logic [DW-1:0]          track_exp,
   output logic                   track_armed,
   output logic                   track_done,
   output logic [$clog2(DEPTH):0] count
);

   localparam int EW = DW + 1 + SEQ_W;

   logic          push, pop, full, empty, track_push;
   logic [EW-1:0] wr_entry, rd_entry;

   logic [SEQ_W-1:0] seq_q, seq_d;
   logic             track_armed_q, track_armed_d;
   logic             track_done_q, track_done_d;
   logic [DW-1:0]    track_val_q, track_val_d;
   logic [DW-1:0]    track_exp_q, track_exp_d;

   // in_ready comes only from registered occupancy, never from out_ready
   assign in_ready   = !full;
   assign out_valid  = !empty;
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   assign track_push = push && in_track && !track_armed_q;
   assign wr_entry   = {in_data, track_push, seq_q};

   vpipe_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (wr_entry),
      .pop_i       (pop),
      .head_o      (rd_entry),
      .count_o     (count),
      .full_o      (full),
      .empty_o     (empty)
   );

   assign out_data  = rd_entry[EW-1 -: DW];
   assign out_track = rd_entry[SEQ_W];
   assign out_seq   = rd_entry[SEQ_W-1:0];

   always_comb begin
      seq_d         = seq_q;
      track_armed_d = track_armed_q;
      track_done_d  = track_done_q;
      track_val_d   = track_val_q;
      track_exp_d   = {track_val_q[DW-2:0], 1'b1};
      if (push) seq_d = seq_q + 1'b1;
      if (track_push) begin
         track_armed_d = 1'b1;
         track_val_d   = in_data;
      end
      if (pop && out_track) track_done_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seq_q         <= '0;
         track_armed_q <= 1'b0;
         track_done_q  <= 1'b0;
         track_val_q   <= '0;
         track_exp_q   <= DW'(1);
      end else begin
         seq_q         <= seq_d;
         track_armed_q <= track_armed_d;
         track_done_q  <= track_done_d;
         track_val_q   <= track_val_d;
         track_exp_q   <= track_exp_d;
      end
   end

   assign track_armed = track_armed_q;
   assign track_done  = track_done_q;
   assign track_val   = track_val_q;
   assign track_exp   = track_exp_q;

endmodule

// File: tb/tb_vpipe_issue_stage.sv
// tb/tb_vpipe_issue_stage.sv - self-checking bench for vpipe_issue_stage
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_vpipe_issue_stage;

   localparam int DW    = 4;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_track = 1'b0;
   logic          out_ready = 1'b0;
   logic          in_ready, out_valid, out_track, track_armed, track_done;
   logic [DW-1:0] out_data, track_val, track_exp;
   logic [3:0]    out_seq;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   vpipe_pkg::entry_t mq[$];
   int m_seq   = 0;
   int m_tval  = 0;
   int m_exp   = 1;
   bit m_armed = 0;
   bit m_done  = 0;

   vpipe_issue_stage #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_track    (in_track),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_track   (out_track),
      .out_seq     (out_seq),
      .out_ready   (out_ready),
      .track_val   (track_val),
      .track_exp   (track_exp),
      .track_armed (track_armed),
      .track_done  (track_done),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic drive(input bit r, input bit v, input int d, input bit t, input bit ordy);
      rst       = r;
      in_valid  = v;
      in_data   = d[DW-1:0];
      in_track  = t;
      out_ready = ordy;
   endtask

   // One clock: the model applies the rules to the inputs present at the edge; sampling happens at negedge.
   task automatic step();
      bit push, pop, tr;
      int next_exp;
      vpipe_pkg::entry_t e;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_seq = 0; m_armed = 0; m_done = 0; m_tval = 0; m_exp = 1;
      end else begin
         next_exp = (m_tval * 2 + 1) % (1 << DW);
         push = in_valid && (mq.size() < DEPTH);
         pop  = out_ready && (mq.size() != 0);
         if (pop) begin
            if (mq[0].track) m_done = 1;
            void'(mq.pop_front());
         end
         if (push) begin
            tr = in_track && !m_armed;
            e.data  = in_data;
            e.track = tr;
            e.seq   = m_seq[3:0];
            mq.push_back(e);
            m_seq = (m_seq + 1) % 16;
            if (tr) begin
               m_armed = 1;
               m_tval  = int'(in_data);
            end
         end
         m_exp = next_exp;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1, 1, 5, 1, 1);
      step(); step();
      drive(0, 0, 0, 0, 0);
      n_checks++; if (count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      n_checks++; if (track_armed !== 1'b0 || track_done !== 1'b0) begin n_fail++; $display("FAIL reset_track_flags: got armed=%0b done=%0b want 0 0", track_armed, track_done); end
      n_checks++; if (track_val !== 4'h0 || track_exp !== 4'h1) begin n_fail++; $display("FAIL reset_track_regs: got val=%h exp=%h want 0 1", track_val, track_exp); end
   endtask

   task automatic test_basic_fifo();
      drive(0, 1, 3, 0, 0); step();
      n_checks++; if (out_valid !== 1'b1 || out_data !== 4'h3) begin n_fail++; $display("FAIL basic_latency: got valid=%0b data=%h want 1 3", out_valid, out_data); end
      drive(0, 1, 5, 0, 0); step();
      drive(0, 0, 0, 0, 0);
      n_checks++; if (count !== 2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", count); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_full_in_ready: got %0b want 0", in_ready); end
      n_checks++; if (out_data !== 4'h3 || out_seq !== 4'd0) begin n_fail++; $display("FAIL basic_head: got data=%h seq=%0d want 3 0", out_data, out_seq); end
      step();
      n_checks++; if (out_data !== 4'h3 || out_seq !== 4'd0 || count !== 2) begin n_fail++; $display("FAIL basic_stall_hold: got data=%h seq=%0d count=%0d want 3 0 2", out_data, out_seq, count); end
      drive(0, 0, 0, 0, 1); step();
      n_checks++; if (out_data !== 4'h5 || out_seq !== 4'd1 || count !== 1) begin n_fail++; $display("FAIL basic_second_pop: got data=%h seq=%0d count=%0d want 5 1 1", out_data, out_seq, count); end
      step();
      n_checks++; if (out_valid !== 1'b0 || count !== 0) begin n_fail++; $display("FAIL basic_drained: got valid=%0b count=%0d want 0 0", out_valid, count); end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_track();
      drive(0, 1, 7, 1, 0); step();
      drive(0, 0, 0, 0, 0);
      n_checks++; if (track_armed !== 1'b1 || track_val !== 4'h7) begin n_fail++; $display("FAIL track_arm: got armed=%0b val=%h want 1 7", track_armed, track_val); end
      n_checks++; if (track_exp !== 4'h1) begin n_fail++; $display("FAIL track_exp_lag: got %h want 1", track_exp); end
      step();
      n_checks++; if (track_exp !== 4'hF) begin n_fail++; $display("FAIL track_exp: got %h want f", track_exp); end
      n_checks++; if (out_track !== 1'b1 || track_done !== 1'b0) begin n_fail++; $display("FAIL track_head: got track=%0b done=%0b want 1 0", out_track, track_done); end
      drive(0, 0, 0, 0, 1); step();
      drive(0, 0, 0, 0, 0);
      n_checks++; if (track_done !== 1'b1) begin n_fail++; $display("FAIL track_done: got %0b want 1", track_done); end
   endtask

   task automatic test_rearm_ignored();
      drive(0, 1, 2, 1, 0); step();
      drive(0, 0, 0, 0, 0);
      n_checks++; if (out_track !== 1'b0 || out_data !== 4'h2) begin n_fail++; $display("FAIL rearm_entry: got track=%0b data=%h want 0 2", out_track, out_data); end
      step();
      n_checks++; if (track_val !== 4'h7 || track_exp !== 4'hF || track_done !== 1'b1) begin n_fail++; $display("FAIL rearm_hold: got val=%h exp=%h done=%0b want 7 f 1", track_val, track_exp, track_done); end
      drive(0, 0, 0, 0, 1); step();
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_full_push_pop();
      drive(0, 1, 9, 0, 0); step();
      drive(0, 1, 12, 0, 0); step();
      drive(0, 1, 13, 0, 1); step();
      n_checks++; if (count !== 1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pushpop: got count=%0d in_ready=%0b want 1 1", count, in_ready); end
      n_checks++; if (out_data !== 4'hC) begin n_fail++; $display("FAIL full_pushpop_head: got %h want c", out_data); end
      drive(0, 0, 0, 0, 1); step();
      n_checks++; if (count !== 0) begin n_fail++; $display("FAIL full_drain: got %0d want 0", count); end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      drive(1, 0, 0, 0, 0); step();
      for (int i = 0; i < 17; i++) begin
         drive(0, 1, i, 0, 1); step();
         n_checks++; if (out_valid !== 1'b1 || out_seq !== 4'(i % 16) || count !== 1) begin n_fail++; $display("FAIL b2b_seq %0d: got valid=%0b seq=%0d count=%0d want 1 %0d 1", i, out_valid, out_seq, count, i % 16); end
      end
      drive(0, 0, 0, 0, 1); step();
      n_checks++; if (count !== 0) begin n_fail++; $display("FAIL b2b_drain: got %0d want 0", count); end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_rst_flush();
      drive(0, 1, 9, 1, 0); step();
      drive(0, 1, 4, 0, 0); step();
      n_checks++; if (track_armed !== 1'b1 || count !== 2) begin n_fail++; $display("FAIL flush_setup: got armed=%0b count=%0d want 1 2", track_armed, count); end
      drive(1, 1, 6, 1, 0); step();
      drive(0, 0, 0, 0, 0);
      n_checks++; if (count !== 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_count: got count=%0d valid=%0b want 0 0", count, out_valid); end
      n_checks++; if (track_armed !== 1'b0 || track_done !== 1'b0 || track_exp !== 4'h1 || track_val !== 4'h0) begin n_fail++; $display("FAIL flush_track: got armed=%0b done=%0b exp=%h val=%h want 0 0 1 0", track_armed, track_done, track_exp, track_val); end
      drive(0, 1, 11, 1, 0); step();
      drive(0, 0, 0, 0, 0);
      n_checks++; if (track_armed !== 1'b1 || track_val !== 4'hB || out_seq !== 4'd0) begin n_fail++; $display("FAIL flush_rearm: got armed=%0b val=%h seq=%0d want 1 b 0", track_armed, track_val, out_seq); end
      step();
      n_checks++; if (track_exp !== 4'h7) begin n_fail++; $display("FAIL flush_rearm_exp: got %h want 7", track_exp); end
      drive(0, 0, 0, 0, 1); step();
      n_checks++; if (track_done !== 1'b1) begin n_fail++; $display("FAIL flush_done: got %0b want 1", track_done); end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, int'($urandom_range(0, 15)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
         step();
         n_checks++; if (int'(count) != mq.size() || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_occupancy cycle %0d: got count=%0d valid=%0b rdy=%0b want count=%0d", c, count, out_valid, in_ready, mq.size()); end
         if (mq.size() != 0) begin
            n_checks++; if (out_data !== mq[0].data || out_track !== mq[0].track || out_seq !== mq[0].seq) begin n_fail++; $display("FAIL rnd_head cycle %0d: got %h/%0b/%0d want %h/%0b/%0d", c, out_data, out_track, out_seq, mq[0].data, mq[0].track, mq[0].seq); end
         end
         n_checks++; if (track_armed !== m_armed || track_done !== m_done || int'(track_val) != m_tval || int'(track_exp) != m_exp) begin n_fail++; $display("FAIL rnd_track cycle %0d: got a=%0b d=%0b v=%h e=%h want a=%0b d=%0b v=%0h e=%0h", c, track_armed, track_done, track_val, track_exp, m_armed, m_done, m_tval, m_exp); end
      end
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic_fifo();
      test_track();
      test_rearm_ignored();
      test_full_push_pop();
      test_back_to_back();
      test_rst_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
